// File: rtl/feature_map_collector.sv
// feature_map_collector: gathers NUM_POS two-filter position results into a frame buffer,
// then drains the frame as a ready/valid byte stream.
module feature_map_collector #(
  parameter int NUM_POS = 36,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data_0,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_done,
  output logic              busy,
  output logic              overflow
);
  localparam int WC_W = $clog2(NUM_POS + 1);
  localparam int RP_W = $clog2(2 * NUM_POS);
  localparam logic [WC_W-1:0] LAST_POS = WC_W'(NUM_POS - 1);
  localparam logic [RP_W-1:0] LAST_BYTE = RP_W'(2 * NUM_POS - 1);
  typedef enum logic {COLLECT, DRAIN} state_t;
  state_t state_q, state_d;
  logic [WC_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [RP_W-1:0] rd_ptr_q, rd_ptr_d, wr_addr;
  logic frame_done_q, frame_done_d, overflow_q, overflow_d, wr_en, xfer;
  logic [DATA_W-1:0] mem_q [0:2*NUM_POS-1];
  always_comb begin
    wr_en = !reset && state_q == COLLECT && in_valid;
    xfer = state_q == DRAIN && out_ready;
    wr_addr = RP_W'(wr_cnt_q) << 1;
    wr_cnt_d = wr_en ? (wr_cnt_q == LAST_POS ? '0 : wr_cnt_q + 1'b1) : wr_cnt_q;
    rd_ptr_d = xfer ? (rd_ptr_q == LAST_BYTE ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    state_d = (wr_en && wr_cnt_q == LAST_POS) ? DRAIN :
              (xfer && rd_ptr_q == LAST_BYTE) ? COLLECT : state_q;
    frame_done_d = xfer && rd_ptr_q == LAST_BYTE;
    overflow_d = overflow_q || (state_q == DRAIN && in_valid);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= COLLECT;
      wr_cnt_q     <= '0;
      rd_ptr_q     <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end
  // Frame storage is deliberately left out of reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr]                   <= in_data_0;
      mem_q[{wr_addr[RP_W-1:1], 1'b1}] <= in_data_1;
    end
  end
  assign out_valid  = state_q == DRAIN;
  assign busy       = state_q == DRAIN;
  assign out_last   = state_q == DRAIN && rd_ptr_q == LAST_BYTE;
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_feature_map_collector.sv
// tb_feature_map_collector: randomized frames checked against a queue-based frame model.
module tb_feature_map_collector;
  localparam int NP = 36;
  localparam int NB = 2 * NP;
  logic clk = 1'b0;
  logic reset, in_valid, out_ready;
  logic [7:0] in_data_0, in_data_1, out_data;
  logic out_valid, out_last, frame_done, busy, overflow;
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];

  feature_map_collector #(.NUM_POS(NP), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data_0(in_data_0),
    .in_data_1(in_data_1), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .frame_done(frame_done),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Drives NP strobes separated by 0..max_gap idle cycles; the model is the expected byte order.
  task automatic send_frame(input int max_gap, input bit directed);
    logic [7:0] d0, d1;
    exp_q.delete();
    for (int k = 0; k < NP; k++) begin
      int g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        in_valid = 1'b0;
        @(negedge clk);
        chk("gap_busy", busy, 0);
      end
      chk("collect_busy", busy, 0);
      chk("collect_valid", out_valid, 0);
      chk("collect_data", out_data, 0);
      d0 = directed ? 8'(k) : 8'($urandom);
      d1 = directed ? 8'(k + 100) : 8'($urandom);
      in_valid = 1'b1;
      in_data_0 = d0;
      in_data_1 = d1;
      exp_q.push_back(d0);
      exp_q.push_back(d1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("valid_rise", out_valid, 1);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready.
  task automatic drain(input int mode, input bit ovf, input int stop);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    while (idx < stop && cyc < 2000) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_busy", busy, 1);
      chk("drain_data", out_data, exp_q[idx]);
      chk("drain_last", out_last, idx == NB - 1);
      chk("drain_done", frame_done, 0);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(1, 0));
      out_ready = rdy;
      if (ovf) begin
        in_valid = (idx < 2) || 1'($urandom_range(1, 0));
        in_data_0 = 8'hAA;
        in_data_1 = 8'hAA;
      end
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    if (idx < stop) chk("drain_timeout", idx, stop);
    if (stop == NB) begin
      chk("fd_pulse", frame_done, 1);
      chk_idle_outputs("post_frame");
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data_0 = '0;
    in_data_1 = '0;
    #1;
    chk_idle_outputs("reset");
    chk("reset_fd", frame_done, 0);
    chk("reset_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // Full directed frame, always ready.
    send_frame(0, 1'b1);
    drain(0, 1'b0, NB);
    @(negedge clk);
    chk("fd_one_cycle", frame_done, 0);
    chk("ovf_clear", overflow, 0);
    // Backpressure 1,0,0 pattern.
    send_frame(0, 1'b1);
    drain(1, 1'b0, NB);
    @(negedge clk);
    // Sparse random frames with random ready.
    for (int f = 0; f < 2; f++) begin
      send_frame(5, 1'b0);
      drain(2, 1'b0, NB);
      @(negedge clk);
    end
    // Overflow while draining.
    send_frame(2, 1'b1);
    drain(2, 1'b1, NB);
    chk("ovf_set", overflow, 1);
    @(negedge clk);
    chk("ovf_sticky", overflow, 1);
    // Asynchronous reset mid-drain after byte 10.
    send_frame(0, 1'b1);
    drain(0, 1'b0, 11);
    #2 reset = 1'b1;
    #1;
    chk_idle_outputs("async_rst");
    chk("async_rst_fd", frame_done, 0);
    chk("async_rst_ovf", overflow, 0);
    in_valid = 1'b1;
    in_data_0 = 8'h55;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    send_frame(3, 1'b0);
    drain(2, 1'b0, NB);
    // Back-to-back: first strobe of next frame lands in the frame_done cycle.
    send_frame(0, 1'b0);
    drain(2, 1'b0, NB);
    @(negedge clk);
    chk("final_fd", frame_done, 0);
    chk("final_ovf", overflow, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/feature_map_collector.md
FEATURE_MAP_COLLECTOR -- requirements
Module: feature_map_collector

Interface
REQ-001 Parameter NUM_POS, default 36, number of output positions per frame (6x6 feature map).
REQ-002 Parameter DATA_W, default 8, width of every data byte.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  one-cycle strobe; in_data_0/in_data_1 hold one position result.
REQ-006 in_data_0  input  DATA_W  filter-0 result for the current position.
REQ-007 in_data_1  input  DATA_W  filter-1 result for the current position.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_valid  output  1  out_data holds a valid buffered byte.
REQ-010 out_data  output  DATA_W  buffered byte being offered.
REQ-011 out_last  output  1  high with the final byte of the frame (index 2*NUM_POS-1).
REQ-012 frame_done  output  1  one-cycle pulse after the final byte transfers.
REQ-013 busy  output  1  high while in DRAIN.
REQ-014 overflow  output  1  sticky flag: in_valid arrived while in DRAIN.

Function
REQ-015 Two states: COLLECT (after reset) and DRAIN.
REQ-016 COLLECT: each cycle with in_valid=1, write in_data_0 to buffer[2*wr_cnt] and in_data_1 to buffer[2*wr_cnt+1], then increment wr_cnt.
REQ-017 in_valid=0 in COLLECT: no write; wr_cnt holds. Gaps of any length between strobes are legal.
REQ-018 When the NUM_POS-th strobe is accepted, wr_cnt clears and the state moves to DRAIN on that same edge.
REQ-019 Latency: last strobe at edge N -> out_valid=1 with out_data=buffer[0] (first in_data_0) in the cycle after edge N.
REQ-020 Buffer depth 2*NUM_POS bytes; write order matches read order: pos0.f0, pos0.f1, pos1.f0, and so on.
REQ-021 DRAIN: out_valid=1 continuously; out_data=buffer[rd_ptr]; busy=1.
REQ-022 A transfer occurs on an edge where out_valid=1 and out_ready=1; rd_ptr increments by 1 on each transfer.
REQ-023 out_valid=1 and out_ready=0: out_data, out_last and rd_ptr hold unchanged (no drop, no skip).
REQ-024 out_last=1 only when busy=1 and rd_ptr=2*NUM_POS-1; otherwise 0.
REQ-025 Transfer of the last byte:
- state returns to COLLECT and rd_ptr clears on that edge;
- out_valid=0 and busy=0 in the next cycle;
- frame_done=1 for exactly that next cycle.
REQ-026 in_valid=1 while in DRAIN: data discarded, buffer and wr_cnt untouched, overflow set to 1 and held until reset.
REQ-027 in_valid=1 in the first COLLECT cycle after the last transfer: accepted normally as position 0 of the next frame.
REQ-028 out_data=0 whenever out_valid=0; stale buffer contents are never visible.
REQ-029 Data is stored and forwarded unmodified: no arithmetic and no saturation inside this block.
REQ-030 wr_cnt width ceil(log2(NUM_POS+1)) and rd_ptr width ceil(log2(2*NUM_POS)); neither counter wraps past its limit.

Reset
REQ-031 reset=1 forces, immediately and without waiting for clk:
- state COLLECT; wr_cnt=0, rd_ptr=0;
- out_valid, out_data, out_last, frame_done, busy and overflow all 0.
REQ-032 Buffer contents are not reset.
REQ-033 Reset asserted mid-COLLECT or mid-DRAIN aborts the frame; the first strobe after release is position 0.
REQ-034 in_valid is ignored while reset=1.

Verification
REQ-035 Full frame, out_ready=1 throughout:
- stimulus: 36 strobes with in_data_0=k, in_data_1=k+100, k=0..35;
- response: 72 bytes 0,100,1,101,...,35,135 on consecutive cycles;
- out_last on byte 71; frame_done one cycle later.
REQ-036 Backpressure:
- stimulus: out_ready toggled 1,0,0,1,...;
- response: out_data holds during each stall, byte sequence unchanged from REQ-035, no duplicated bytes.
REQ-037 Sparse input:
- stimulus: 36 strobes separated by 0-5 idle cycles;
- response: out_valid rises exactly one cycle after the 36th strobe; busy=0 before that.
REQ-038 Overflow:
- stimulus: in_valid=1 during DRAIN with in_data_0=0xAA;
- response: overflow=1 and stays 1; 0xAA never appears on out_data; drained bytes match the original frame.
REQ-039 Async reset mid-DRAIN:
- stimulus: assert reset between clock edges after byte 10;
- response: all outputs 0 before the next edge;
- after release, a new 36-strobe frame drains correctly from byte 0.
REQ-040 Back-to-back frames: a strobe in the frame_done cycle is captured as position 0 of the next frame, and the second frame drains correctly.
